// File: rtl/dm_pkg.sv
// Shared constants for the dm_arb2 data-memory arbiter: requester ID width,
// legal read-latency range, lock-state encoding and the winner-select helper.
package dm_pkg;

  localparam int ID_W       = 1;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  localparam logic [1:0] LK_UNLOCKED = 2'd0;
  localparam logic [1:0] LK_LOCKED0  = 2'd1;
  localparam logic [1:0] LK_LOCKED1  = 2'd2;

  // A lone requester always wins; on contention the priority pointer decides.
  function automatic logic [ID_W-1:0] pick_winner(input logic req0,
                                                  input logic req1,
                                                  input logic prio);
    logic [ID_W-1:0] w;
    w = 1'b0;
    if (req1 && !req0)
      w = 1'b1;
    else if (req0 && req1)
      w = prio;
    return w;
  endfunction

endpackage

// File: rtl/dm_rd_track.sv
// Read-return tracker: an RD_LAT-deep {valid, id} shift register that tags
// each accepted read with its requester, so returning memory data can be
// steered to the requester that issued it. Shifts every cycle.
module dm_rd_track
  import dm_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_v,
  input  logic [ID_W-1:0] in_id,
  output logic            r0_rvalid,
  output logic            r1_rvalid
);

  logic [RD_LAT-1:0] v_pipe;
  logic [ID_W-1:0]   id_pipe [RD_LAT];

  // Valid bits are control state and are cleared on reset, dropping in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_pipe <= '0;
    end else begin
      v_pipe[0] <= in_v;
      for (int i = 1; i < RD_LAT; i++)
        v_pipe[i] <= v_pipe[i-1];
    end
  end

  // Requester tags ride alongside the valid bits; they are meaningless when v=0.
  always_ff @(posedge clk) begin
    id_pipe[0] <= in_id;
    for (int i = 1; i < RD_LAT; i++)
      id_pipe[i] <= id_pipe[i-1];
  end

  // --- last stage: decode the tag into per-requester valids
  assign r0_rvalid = ~rst & v_pipe[RD_LAT-1] & (id_pipe[RD_LAT-1] == 1'b0);
  assign r1_rvalid = ~rst & v_pipe[RD_LAT-1] & (id_pipe[RD_LAT-1] == 1'b1);

endmodule

// File: rtl/dm_arb2.sv
// dm_arb2: two-requester round-robin arbiter in front of one data-memory port.
// Zero-cycle grant, honours mem_bsy back-pressure, and routes read data back
// to the issuing requester after RD_LAT cycles (RD_LAT legal range 1..4).
// Optional feature: define DM_ARB2_LOCK_EN to add r0_lock/r1_lock, which let a
// requester hold the port for a locked burst of transfers.
module dm_arb2
  import dm_pkg::*;
#(
  parameter int W      = 16,
  parameter int AW     = 10,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [W-1:0]  r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [W-1:0]  r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [W-1:0]  r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [W-1:0]  r1_rdata,
`ifdef DM_ARB2_LOCK_EN
  input  logic          r0_lock,
  input  logic          r1_lock,
`endif
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [W-1:0]  mem_wdata,
  input  logic [W-1:0]  mem_rdata,
  input  logic          mem_bsy
);

  logic            prio;
  logic [ID_W-1:0] winner;
  logic            elig0;
  logic            elig1;
  logic            accepted;

`ifdef DM_ARB2_LOCK_EN
  logic [1:0] lk_state;

  // While locked to one requester the other one is invisible to arbitration.
  assign elig0 = r0_req & (lk_state != LK_LOCKED1);
  assign elig1 = r1_req & (lk_state != LK_LOCKED0);
`else
  assign elig0 = r0_req;
  assign elig1 = r1_req;
`endif

  assign winner = pick_winner(elig0, elig1, prio);

  // --- request stage: combinational mux toward memory and grant decision
  assign mem_req   = elig0 | elig1;
  assign mem_we    = (winner == 1'b1) ? (elig1 & r1_we) : (elig0 & r0_we);
  assign mem_addr  = (winner == 1'b1) ? r1_addr  : r0_addr;
  assign mem_wdata = (winner == 1'b1) ? r1_wdata : r0_wdata;

  assign r0_gnt   = ~rst & ~mem_bsy & elig0 & (winner == 1'b0);
  assign r1_gnt   = ~rst & ~mem_bsy & elig1 & (winner == 1'b1);
  assign accepted = r0_gnt | r1_gnt;

  // Loser of an accepted transfer gets priority next; idle/busy cycles hold it.
  // Inside a lock the winner is always the owner, so this leaves prio = ~owner.
  always_ff @(posedge clk) begin
    if (rst)
      prio <= 1'b0;
    else if (accepted)
      prio <= ~winner[0];
  end

`ifdef DM_ARB2_LOCK_EN
  // Lock FSM: enter on a granted transfer with lock=1, leave on the owner's
  // first granted transfer with lock=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      lk_state <= LK_UNLOCKED;
    end else begin
      case (lk_state)
        LK_UNLOCKED: begin
          if (r0_gnt && r0_lock)
            lk_state <= LK_LOCKED0;
          else if (r1_gnt && r1_lock)
            lk_state <= LK_LOCKED1;
        end
        LK_LOCKED0: if (r0_gnt && !r0_lock) lk_state <= LK_UNLOCKED;
        LK_LOCKED1: if (r1_gnt && !r1_lock) lk_state <= LK_UNLOCKED;
        default:    lk_state <= LK_UNLOCKED;
      endcase
    end
  end
`endif

  // --- return stage: latency-matched tag pipe steers mem_rdata
  dm_rd_track #(
    .RD_LAT (RD_LAT)
  ) u_rd_track (
    .clk       (clk),
    .rst       (rst),
    .in_v      (accepted & ~mem_we),
    .in_id     (winner),
    .r0_rvalid (r0_rvalid),
    .r1_rvalid (r1_rvalid)
  );

  assign r0_rdata = r0_rvalid ? mem_rdata : '0;
  assign r1_rdata = r1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dm_arb2.sv
// Testbench for dm_arb2: two instances (RD_LAT=1 and RD_LAT=3) share requester
// stimulus; each has its own behavioural memory. A vector table drives the
// RD_LAT=1 instance; hand sequences cover reset drop, latency and locking.
module tb_dm_arb2;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r1_req, r1_we, mem_bsy;
  logic [9:0]  r0_addr, r1_addr;
  logic [15:0] r0_wdata, r1_wdata;
`ifdef DM_ARB2_LOCK_EN
  logic        r0_lock, r1_lock;
`endif

  logic        g0_1, g1_1, v0_1, v1_1, mreq1, mwe1;
  logic [15:0] d0_1, d1_1, mwd1, mrd1;
  logic [9:0]  ma1;
  logic        g0_3, g1_3, v0_3, v1_3, mreq3, mwe3;
  logic [15:0] d0_3, d1_3, mwd3, mrd3;
  logic [9:0]  ma3;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dm_arb2 #(.W(16), .AW(10), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(g0_1), .r0_rvalid(v0_1), .r0_rdata(d0_1),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(g1_1), .r1_rvalid(v1_1), .r1_rdata(d1_1),
`ifdef DM_ARB2_LOCK_EN
    .r0_lock(r0_lock), .r1_lock(r1_lock),
`endif
    .mem_req(mreq1), .mem_we(mwe1), .mem_addr(ma1), .mem_wdata(mwd1),
    .mem_rdata(mrd1), .mem_bsy(mem_bsy)
  );

  dm_arb2 #(.W(16), .AW(10), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(g0_3), .r0_rvalid(v0_3), .r0_rdata(d0_3),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(g1_3), .r1_rvalid(v1_3), .r1_rdata(d1_3),
`ifdef DM_ARB2_LOCK_EN
    .r0_lock(r0_lock), .r1_lock(r1_lock),
`endif
    .mem_req(mreq3), .mem_we(mwe3), .mem_addr(ma3), .mem_wdata(mwd3),
    .mem_rdata(mrd3), .mem_bsy(mem_bsy)
  );

  // Behavioural memories: preloaded with A000+addr, data valid RD_LAT cycles
  // after an accepted read.
  logic [15:0] mem1 [1024];
  logic [15:0] mem3 [1024];
  logic [15:0] rp3  [3];
  logic        acc1, acc3;

  assign acc1 = g0_1 | g1_1;
  assign acc3 = g0_3 | g1_3;
  assign mrd3 = rp3[2];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = 16'hA000 + 16'(i);
      mem3[i] = 16'hA000 + 16'(i);
    end
    mrd1 = 16'h0;
    for (int i = 0; i < 3; i++) rp3[i] = 16'h0;
  end

  always @(posedge clk) begin
    if (acc1 && mwe1)  mem1[ma1] <= mwd1;
    if (acc1 && !mwe1) mrd1 <= mem1[ma1];
  end

  always @(posedge clk) begin
    if (acc3 && mwe3) mem3[ma3] <= mwd3;
    rp3[0] <= (acc3 && !mwe3) ? mem3[ma3] : 16'hDEAD;
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end

  typedef struct {
    logic rst, bsy;
    logic q0, w0; logic [9:0] a0; logic [15:0] d0;
    logic q1, w1; logic [9:0] a1; logic [15:0] d1;
    logic eg0, eg1, ev0, ev1;
    logic [15:0] ed0, ed1;
  } vec_t;

  function automatic vec_t mk(logic rs, logic bs,
                              logic q0, logic w0, logic [9:0] a0, logic [15:0] d0,
                              logic q1, logic w1, logic [9:0] a1, logic [15:0] d1,
                              logic eg0, logic eg1, logic ev0, logic ev1,
                              logic [15:0] ed0, logic [15:0] ed1);
    vec_t v;
    v.rst = rs; v.bsy = bs;
    v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1; v.ev0 = ev0; v.ev1 = ev1;
    v.ed0 = ed0; v.ed1 = ed1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic q0, input logic w0, input logic [9:0] a0, input logic [15:0] d0,
                       input logic q1, input logic w1, input logic [9:0] a1, input logic [15:0] d1);
    r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
    r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
  endtask

  vec_t vt [18];

  initial begin
`ifdef DM_ARB2_LOCK_EN
    r0_lock = 1'b0; r1_lock = 1'b0;
`endif
    rst = 1'b1; mem_bsy = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    //          rst bsy  q0 w0 a0  d0       q1 w1 a1  d1       eg0 eg1 ev0 ev1 ed0       ed1
    vt[0]  = mk(1, 0,   1, 0, 5,  0,       1, 0, 6,  0,       0, 0, 0, 0, 0,        0);
    vt[1]  = mk(0, 0,   1, 0, 5,  0,       0, 0, 0,  0,       1, 0, 0, 0, 0,        0);
    vt[2]  = mk(0, 0,   0, 0, 0,  0,       0, 0, 0,  0,       0, 0, 1, 0, 16'hA005, 0);
    vt[3]  = mk(1, 0,   0, 0, 0,  0,       0, 0, 0,  0,       0, 0, 0, 0, 0,        0);
    vt[4]  = mk(0, 0,   1, 0, 10, 0,       1, 0, 11, 0,       1, 0, 0, 0, 0,        0);
    vt[5]  = mk(0, 0,   1, 0, 12, 0,       1, 0, 11, 0,       0, 1, 1, 0, 16'hA00A, 0);
    vt[6]  = mk(0, 0,   1, 0, 12, 0,       1, 0, 13, 0,       1, 0, 0, 1, 0,        16'hA00B);
    vt[7]  = mk(0, 0,   1, 0, 14, 0,       1, 0, 13, 0,       0, 1, 1, 0, 16'hA00C, 0);
    vt[8]  = mk(0, 1,   1, 0, 14, 0,       1, 0, 15, 0,       0, 0, 0, 1, 0,        16'hA00D);
    vt[9]  = mk(0, 1,   1, 0, 14, 0,       1, 0, 15, 0,       0, 0, 0, 0, 0,        0);
    vt[10] = mk(0, 0,   1, 0, 14, 0,       1, 0, 15, 0,       1, 0, 0, 0, 0,        0);
    vt[11] = mk(0, 0,   0, 0, 0,  0,       1, 0, 15, 0,       0, 1, 1, 0, 16'hA00E, 0);
    vt[12] = mk(0, 0,   0, 0, 0,  0,       1, 1, 32, 16'h7,   0, 1, 0, 1, 0,        16'hA00F);
    vt[13] = mk(0, 0,   1, 0, 32, 0,       0, 0, 0,  0,       1, 0, 0, 0, 0,        0);
    vt[14] = mk(0, 0,   0, 0, 0,  0,       0, 0, 0,  0,       0, 0, 1, 0, 16'h0007, 0);
    vt[15] = mk(0, 1,   1, 0, 1,  0,       1, 0, 2,  0,       0, 0, 0, 0, 0,        0);
    vt[16] = mk(0, 0,   1, 0, 1,  0,       0, 0, 0,  0,       1, 0, 0, 0, 0,        0);
    vt[17] = mk(0, 0,   0, 0, 0,  0,       0, 0, 0,  0,       0, 0, 1, 0, 16'hA001, 0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst = vt[i].rst; mem_bsy = vt[i].bsy;
      drive(vt[i].q0, vt[i].w0, vt[i].a0, vt[i].d0, vt[i].q1, vt[i].w1, vt[i].a1, vt[i].d1);
      #2;
      chk($sformatf("v%0d r0_gnt", i),    32'(g0_1), 32'(vt[i].eg0));
      chk($sformatf("v%0d r1_gnt", i),    32'(g1_1), 32'(vt[i].eg1));
      chk($sformatf("v%0d r0_rvalid", i), 32'(v0_1), 32'(vt[i].ev0));
      chk($sformatf("v%0d r1_rvalid", i), 32'(v1_1), 32'(vt[i].ev1));
      chk($sformatf("v%0d r0_rdata", i),  32'(d0_1), 32'(vt[i].ed0));
      chk($sformatf("v%0d r1_rdata", i),  32'(d1_1), 32'(vt[i].ed1));
    end

    // RD_LAT=3: read accepted, then reset the next cycle drops it.
    @(negedge clk);
    rst = 1'b0; mem_bsy = 1'b0;
    drive(1, 0, 7, 0, 0, 0, 0, 0);
    #2 chk("lat3 pre-reset r0_gnt", 32'(g0_3), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rst = 1'b0;
      #2;
      chk($sformatf("lat3 dropped r0_rvalid c%0d", k), 32'(v0_3), 32'd0);
      chk($sformatf("lat3 dropped r1_rvalid c%0d", k), 32'(v1_3), 32'd0);
    end

    // First contention after reset goes to r0.
    @(negedge clk);
    drive(1, 0, 20, 0, 1, 0, 21, 0);
    #2;
    chk("lat3 post-reset r0_gnt", 32'(g0_3), 32'd1);
    chk("lat3 post-reset r1_gnt", 32'(g1_3), 32'd0);

    // That read returns exactly three cycles later.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      chk($sformatf("lat3 r0_rvalid +%0d", k), 32'(v0_3), (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("lat3 r0_rdata +%0d", k),  32'(d0_3), (k == 3) ? 32'hA014 : 32'd0);
      chk($sformatf("lat3 r1_rvalid +%0d", k), 32'(v1_3), 32'd0);
    end

`ifdef DM_ARB2_LOCK_EN
    // prio points at r1 here; r1 locks the port for four writes while r0 waits.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1, 0, 3, 0, 1, 1, 10'(40 + k), 16'(k));
      r1_lock = (k < 3);
      #2;
      chk($sformatf("lock w%0d r1_gnt", k), 32'(g1_1), (k < 4) ? 32'd1 : 32'd0);
      chk($sformatf("lock w%0d r0_gnt", k), 32'(g0_1), (k < 4) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    r1_lock = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_arb2.md
Name: dm_arb2

Overview:
- Two-requester round-robin arbiter sharing one data-memory port.
- Typical use: a matrix engine and a host/DMA loader contend for the same RAM bank; the arbiter sits between both and the data memory monitor.
- Honors memory back-pressure (mem_bsy).
- Tracks in-flight reads so each read's returned data is routed back to the requester that issued it.

Parameters:
W, 16, data width
AW, 10, word address width
RD_LAT, 1, cycles from accepted read to mem_rdata valid; legal 1..4

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
r0_req  in  1  requester 0 access request
r0_we  in  1  requester 0 write enable (0 = read)
r0_addr  in  AW  requester 0 address
r0_wdata  in  W  requester 0 write data
r0_gnt  out  1  requester 0 transfer accepted this cycle
r0_rvalid  out  1  read data for requester 0 valid
r0_rdata  out  W  read data for requester 0
r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  (same as r0_*, for requester 1)
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  W  memory write data
mem_rdata  in  W  memory read data
mem_bsy  in  1  memory busy; no request accepted while high

Interface:
- One clock domain, clk.
- Reset rst is synchronous and active-high.

Behaviour:
- Winner selection (combinational):
  - Only one requester: that requester wins.
  - Both requesting: the requester indicated by the priority pointer `prio` (0 or 1) wins.
- Memory drive:
  - mem_req = r0_req | r1_req.
  - mem_we, mem_addr and mem_wdata are muxed from the winner.
  - With no request: mem_we = 0; addr/wdata are don't-care but are driven from r0.
- Grant: rN_gnt = winner==N & rNreq & ~mem_bsy. Zero-cycle decision; a transfer occurs in any cycle where a gnt is high.
- Requester contract:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - Requester may deassert req without a gnt (withdraw); the arbiter must tolerate this.
- Priority pointer:
  - Updates only on an accepted transfer: prio <= ~winner, so the loser has priority next cycle.
  - Unchanged while mem_bsy=1 or idle.
  - Reset value 0 (r0 favoured).
- Read tracking:
  - Shift register of RD_LAT entries {v, id}.
  - Stage 0 loads v = (accepted & ~mem_we) and id = winner; the register shifts every cycle regardless of mem_bsy.
  - At the last stage: rN_rvalid = v & id==N, and rN_rdata = mem_rdata when rvalid, else 0.
  - Writes produce no rvalid.
- Throughput: one transfer per cycle when mem_bsy=0. Back-to-back reads from alternating requesters return in issue order.
- Reset: clears the tracking pipe (v=0), prio=0, and all rvalid outputs.
  - gnt outputs are combinational but forced to 0 while rst=1.
  - Reset mid-operation silently drops in-flight reads; no rvalid appears after reset.
- Boundary cases:
  - mem_bsy high with both requesting: no gnt and prio holds. On release, the prio side wins first.
  - Simultaneous read return and new issue: independent; the pipe handles both.
  - RD_LAT=1 degenerates to a single register stage.

Optional Feature:
- Macro DM_ARB2_LOCK_EN adds inputs r0_lock and r1_lock.
- With the macro defined:
  - When requester N gets a gnt with rN_lock=1, the arbiter enters LOCKED(N).
  - In LOCKED(N), only N can win and the other requester is masked.
  - Exit on the first accepted transfer from N with rN_lock=0, or on rst.
  - prio does not change while locked. On exit, prio = ~N.
  - State set: {UNLOCKED, LOCKED0, LOCKED1}.
- Without the macro: no lock ports and pure round-robin, identical to lock always 0.

Decomposition:
- Shared package `dm_pkg`:
  - requester-ID width constant (1)
  - RD_LAT bounds constants
  - lock-state encoding constants
- One natural sub-module: `dm_rd_track`, the RD_LAT-deep {v,id} pipeline that produces the per-requester rvalid.
- Arbitration, mux and lock FSM stay in dm_arb2.

Test Plan:
- r0 only, read addr 5, RD_LAT=1 -> r0_gnt same cycle; next cycle r0_rvalid=1 with r0_rdata=mem[5]; r1_rvalid stays 0.
- Both request reads continuously, mem_bsy=0 -> gnts alternate r0,r1,r0,r1 starting with r0 after reset; returned data routed to the matching requester in order.
- Both requesting with mem_bsy asserted 2 of every 12 cycles -> no gnt while busy; alternation pattern unbroken across each busy window.
- r1 writes addr 32 = 16'h0007, then r0 reads addr 32 -> r0_rdata = 16'h0007; no rvalid generated for the write.
- Reset asserted the cycle after an accepted read with RD_LAT=3 -> no rvalid for that read; first post-reset contention grants r0.
- DM_ARB2_LOCK_EN: r1 issues 4 locked writes, last with lock=0, while r0 requests throughout -> r1 gets 4 consecutive gnts, then r0 is granted.
